// File: rtl/sha256_block_hasher_if.sv
// Block-in / digest-out handshake bundle for the SHA-256 block hasher.
interface sha256_block_hasher_if;
  logic         validIn;
  logic         readyOut;
  logic         firstBlock;
  logic         lastBlock;
  logic [511:0] block;
  logic         validHashOut;
  logic         readyHashIn;
  logic [255:0] hash;

  modport master (
    output validIn, firstBlock, lastBlock, block, readyHashIn,
    input  readyOut, validHashOut, hash
  );

  modport slave (
    input  validIn, firstBlock, lastBlock, block, readyHashIn,
    output readyOut, validHashOut, hash
  );
endinterface

// File: rtl/sha256_block_hasher.sv
// SHA-256 compression engine: one pre-padded 512-bit block per handshake, chained digests.
// Define HASHER_TWO_ROUNDS_EN to run two rounds per clock (32 round cycles instead of 64).
module sha256_block_hasher (
  input  logic                 clk,
  input  logic                 rst,
  sha256_block_hasher_if.slave bus
);

  localparam logic [255:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {IDLE_RST, IDLE, ROUNDS, FINAL, PUBLISH, OUTPUT} state_t;

  state_t       state;
  logic [255:0] chainH;
  logic [255:0] work;
  logic [255:0] roundNext;
  logic [31:0]  w [16];
  logic [31:0]  wNext [16];
  logic [5:0]   roundIdx;
  logic         firstReg;
  logic         lastReg;

  function automatic logic [31:0] bigS0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bigS1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] smallS0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] smallS1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Working vars are packed {a,b,c,d,e,f,g,h} with a in the top word.
  function automatic logic [255:0] doRound(input logic [255:0] s, input logic [31:0] k,
                                           input logic [31:0] wt);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + bigS1(e) + ((e & f) ^ (~e & g)) + k + wt;
    t2 = bigS0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // Window holds W[t..t+15]; this yields W[t+16].
  function automatic logic [31:0] nextW(input logic [31:0] w0, input logic [31:0] w1,
                                        input logic [31:0] w9, input logic [31:0] w14);
    return smallS1(w14) + w9 + smallS0(w1) + w0;
  endfunction

  function automatic logic [255:0] addWords(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
    return r;
  endfunction

`ifdef HASHER_TWO_ROUNDS_EN
  localparam logic [5:0] ROUND_STEP = 6'd2;
  localparam logic [5:0] LAST_ROUND = 6'd62;

  always_comb begin
    wNext = w;
    roundNext = doRound(doRound(work, K[roundIdx], w[0]), K[roundIdx + 6'd1], w[1]);
    for (int i = 0; i < 14; i++) wNext[i] = w[i + 2];
    wNext[14] = nextW(w[0], w[1], w[9], w[14]);
    wNext[15] = nextW(w[1], w[2], w[10], w[15]);
  end
`else
  localparam logic [5:0] ROUND_STEP = 6'd1;
  localparam logic [5:0] LAST_ROUND = 6'd63;

  always_comb begin
    wNext = w;
    roundNext = doRound(work, K[roundIdx], w[0]);
    for (int i = 0; i < 15; i++) wNext[i] = w[i + 1];
    wNext[15] = nextW(w[0], w[1], w[9], w[14]);
  end
`endif

  // The chain add and the digest publish sit in separate cycles (FINAL, PUBLISH).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE_RST;
      bus.readyOut     <= 1'b0;
      bus.validHashOut <= 1'b0;
      bus.hash         <= '0;
      chainH           <= H_INIT;
      work             <= '0;
      roundIdx         <= '0;
      firstReg         <= 1'b0;
      lastReg          <= 1'b0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      case (state)
        IDLE_RST: begin
          state        <= IDLE;
          bus.readyOut <= 1'b1;
        end
        IDLE: begin
          if (bus.validIn) begin
            for (int i = 0; i < 16; i++) w[i] <= bus.block[511 - 32*i -: 32];
            work         <= bus.firstBlock ? H_INIT : chainH;
            firstReg     <= bus.firstBlock;
            lastReg      <= bus.lastBlock;
            roundIdx     <= '0;
            bus.readyOut <= 1'b0;
            state        <= ROUNDS;
          end
        end
        ROUNDS: begin
          work     <= roundNext;
          w        <= wNext;
          roundIdx <= roundIdx + ROUND_STEP;
          if (roundIdx == LAST_ROUND) state <= FINAL;
        end
        FINAL: begin
          chainH <= addWords(firstReg ? H_INIT : chainH, work);
          state  <= PUBLISH;
        end
        PUBLISH: begin
          if (lastReg) begin
            bus.hash         <= chainH;
            bus.validHashOut <= 1'b1;
            state            <= OUTPUT;
          end else begin
            bus.readyOut <= 1'b1;
            state        <= IDLE;
          end
        end
        OUTPUT: begin
          if (bus.readyHashIn) begin
            bus.validHashOut <= 1'b0;
            bus.readyOut     <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_hasher.sv
// Self-checking bench for sha256_block_hasher against a full-schedule SHA-256 reference model.
// Honours HASHER_TWO_ROUNDS_EN for the expected latency.
module tb_sha256_block_hasher;

`ifdef HASHER_TWO_ROUNDS_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 66;
`endif

  localparam logic [255:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_HASH =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] TWO_BLK1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_BLK2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] TWO_HASH =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic [31:0] kTab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk;
  logic         rst;
  logic [255:0] refChain;
  int           checks;
  int           fails;

  sha256_block_hasher_if bus ();

  sha256_block_hasher dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word schedule, then 64 rounds, then feed-forward.
  function automatic logic [255:0] refCompress(input logic [255:0] hIn, input logic [511:0] blk);
    logic [31:0] sch [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) sch[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(sch[t-15], 7) ^ rotr(sch[t-15], 18) ^ (sch[t-15] >> 3);
      s1 = rotr(sch[t-2], 17) ^ rotr(sch[t-2], 19) ^ (sch[t-2] >> 10);
      sch[t] = s1 + sch[t-7] + s0 + sch[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hIn[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kTab[t] + sch[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hIn[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] randBlock();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom())};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one block, updates the model, and waits for completion with latency checks.
  task automatic sendBlock(input logic [511:0] blk, input bit first, input bit last, input bit junk);
    int cycles;
    int guard;
    bit done;
    bit early;
    guard = 0;
    while (bus.readyOut !== 1'b1 && guard < 300) begin
      tick();
      guard++;
    end
    checks++;
    if (bus.readyOut !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_wait: readyOut=%b expected 1", bus.readyOut);
    end
    bus.validIn    = 1'b1;
    bus.block      = blk;
    bus.firstBlock = first;
    bus.lastBlock  = last;
    tick();
    bus.validIn = 1'b0;
    refChain = refCompress(first ? H_INIT : refChain, blk);
    cycles = 0;
    done   = 1'b0;
    early  = 1'b0;
    while (!done && cycles < LAT + 20) begin
      if (junk && cycles >= 4 && cycles < 8) begin
        bus.validIn    = 1'b1;
        bus.block      = randBlock();
        bus.firstBlock = 1'b1;
        bus.lastBlock  = 1'b1;
      end else begin
        bus.validIn = 1'b0;
      end
      tick();
      cycles++;
      done = last ? (bus.validHashOut === 1'b1) : (bus.readyOut === 1'b1);
      if (!done && (bus.readyOut !== 1'b0 || bus.validHashOut !== 1'b0)) early = 1'b1;
    end
    checks++;
    if (cycles != LAT || !done) begin
      fails++;
      $display("[TB] FAIL latency: got %0d cycles (done=%b), expected %0d", cycles, done, LAT);
    end
    checks++;
    if (early || (last && bus.readyOut !== 1'b0) || (!last && bus.validHashOut !== 1'b0)) begin
      fails++;
      $display("[TB] FAIL busy_flags: early=%b readyOut=%b validHashOut=%b expected busy-low",
               early, bus.readyOut, bus.validHashOut);
    end
    if (last) begin
      checks++;
      if (bus.hash !== refChain) begin
        fails++;
        $display("[TB] FAIL digest: got %h expected %h", bus.hash, refChain);
      end
    end
  endtask

  task automatic acceptDigest(input logic [255:0] exp, input int hold);
    bus.readyHashIn = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (bus.validHashOut !== 1'b1 || bus.hash !== exp) begin
        fails++;
        $display("[TB] FAIL hold_stable: validHashOut=%b hash=%h expected 1 / %h",
                 bus.validHashOut, bus.hash, exp);
      end
    end
    bus.readyHashIn = 1'b1;
    tick();
    bus.readyHashIn = 1'b0;
    checks++;
    if (bus.validHashOut !== 1'b0 || bus.readyOut !== 1'b1) begin
      fails++;
      $display("[TB] FAIL handshake: validHashOut=%b readyOut=%b expected 0/1",
               bus.validHashOut, bus.readyOut);
    end
    checks++;
    if (bus.hash !== exp) begin
      fails++;
      $display("[TB] FAIL hash_kept: got %h expected %h", bus.hash, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.readyOut !== 1'b0 || bus.validHashOut !== 1'b0 || bus.hash !== 256'h0) begin
      fails++;
      $display("[TB] FAIL reset_state: readyOut=%b validHashOut=%b hash=%h expected 0/0/0",
               bus.readyOut, bus.validHashOut, bus.hash);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.readyOut !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_release: readyOut=%b expected 0 before first edge", bus.readyOut);
    end
    tick();
    checks++;
    if (bus.readyOut !== 1'b1) begin
      fails++;
      $display("[TB] FAIL idle_ready: readyOut=%b expected 1", bus.readyOut);
    end
  endtask

  task automatic test_abc();
    sendBlock(ABC_BLK, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.hash !== ABC_HASH) begin
      fails++;
      $display("[TB] FAIL abc_known: got %h expected %h", bus.hash, ABC_HASH);
    end
    acceptDigest(ABC_HASH, 4);
  endtask

  task automatic test_two_block();
    sendBlock(TWO_BLK1, 1'b1, 1'b0, 1'b0);
    sendBlock(TWO_BLK2, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.hash !== TWO_HASH) begin
      fails++;
      $display("[TB] FAIL two_block_known: got %h expected %h", bus.hash, TWO_HASH);
    end
    acceptDigest(TWO_HASH, 1);
  endtask

  task automatic test_pulse();
    bus.readyHashIn = 1'b1;
    sendBlock(randBlock(), 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus.validHashOut !== 1'b0 || bus.readyOut !== 1'b1) begin
      fails++;
      $display("[TB] FAIL pulse: validHashOut=%b readyOut=%b expected 0/1",
               bus.validHashOut, bus.readyOut);
    end
    bus.readyHashIn = 1'b0;
  endtask

  task automatic test_ignore();
    sendBlock(ABC_BLK, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.hash !== ABC_HASH) begin
      fails++;
      $display("[TB] FAIL ignore_busy: got %h expected %h", bus.hash, ABC_HASH);
    end
    acceptDigest(ABC_HASH, 2);
  endtask

  task automatic test_chain_from_digest();
    sendBlock(randBlock(), 1'b1, 1'b1, 1'b0);
    acceptDigest(refChain, 1);
    sendBlock(randBlock(), 1'b0, 1'b1, 1'b0);
    acceptDigest(refChain, 0);
  endtask

  task automatic test_random();
    int nBlk;
    for (int m = 0; m < 4; m++) begin
      nBlk = $urandom_range(1, 3);
      for (int b = 0; b < nBlk; b++)
        sendBlock(randBlock(), b == 0, b == nBlk - 1, 1'b0);
      acceptDigest(refChain, $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid();
    bus.validIn    = 1'b1;
    bus.block      = randBlock();
    bus.firstBlock = 1'b1;
    bus.lastBlock  = 1'b1;
    tick();
    bus.validIn = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.readyOut !== 1'b0 || bus.validHashOut !== 1'b0 || bus.hash !== 256'h0) begin
      fails++;
      $display("[TB] FAIL mid_reset: readyOut=%b validHashOut=%b hash=%h expected 0/0/0",
               bus.readyOut, bus.validHashOut, bus.hash);
    end
    refChain = H_INIT;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.readyOut !== 1'b1 || bus.validHashOut !== 1'b0) begin
      fails++;
      $display("[TB] FAIL post_reset_idle: readyOut=%b validHashOut=%b expected 1/0",
               bus.readyOut, bus.validHashOut);
    end
    // A non-first block right after reset must chain from H_INIT, yielding the "abc" digest.
    sendBlock(ABC_BLK, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.hash !== ABC_HASH) begin
      fails++;
      $display("[TB] FAIL rerun_abc: got %h expected %h", bus.hash, ABC_HASH);
    end
    acceptDigest(ABC_HASH, 1);
  endtask

  initial begin
    checks          = 0;
    fails           = 0;
    refChain        = H_INIT;
    rst             = 1'b1;
    bus.validIn     = 1'b0;
    bus.firstBlock  = 1'b0;
    bus.lastBlock   = 1'b0;
    bus.block       = '0;
    bus.readyHashIn = 1'b0;
    test_reset();
    test_abc();
    test_two_block();
    test_pulse();
    test_ignore();
    test_chain_from_digest();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
